// File: rtl/svd_pkg.sv
// +------------------------------------------------------------------+
// | svd_pkg : shared types and widths for the ERFHSVD rotation path  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package svd_pkg;

  localparam int WORD_LENGTH = 16;
  localparam int TAG_LENGTH  = 8;

  // Signed width able to hold the difference of two bit indices.
  function automatic int exp_w(input int width);
    return $clog2(width) + 1;
  endfunction

  typedef struct packed {
    logic signed [WORD_LENGTH-1:0] a;
    logic signed [WORD_LENGTH-1:0] b;
    logic signed [WORD_LENGTH-1:0] c;
    logic signed [WORD_LENGTH-1:0] d;
    logic [TAG_LENGTH-1:0]         tag;
  } rot_in_t;

  typedef struct packed {
    logic [WORD_LENGTH-1:0]                  n1;
    logic [WORD_LENGTH-1:0]                  d1;
    logic [WORD_LENGTH-1:0]                  n2;
    logic [WORD_LENGTH-1:0]                  d2;
    logic signed [exp_w(WORD_LENGTH)-1:0]    k1;
    logic signed [exp_w(WORD_LENGTH)-1:0]    k2;
    logic                                    sx1;
    logic                                    sx2;
    logic [3:0]                              nz;
    logic                                    ovf;
    logic [TAG_LENGTH-1:0]                   tag;
  } rot_out_t;

endpackage

`default_nettype wire

// File: rtl/svd_msb_encode.sv
// +------------------------------------------------------------------+
// | svd_msb_encode : highest-set-bit index plus zero flag (comb.)    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module svd_msb_encode #(
  parameter int WIDTH = 16,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] x,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);

  // Ascending scan: the last set bit seen wins, giving the highest index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) idx = IDX_W'(i);
    end
  end

  assign zero = (x == '0);

endmodule

`default_nettype wire

// File: rtl/svd_rotation_angles_pipe.sv
// +------------------------------------------------------------------+
// | svd_rotation_angles_pipe : 3-stage 2x2 rotation-angle front end  |
// | SVD_ROT_SAT_EN: saturate oversize magnitudes (default wraps)     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module svd_rotation_angles_pipe
  import svd_pkg::*;
#(
  parameter int WIDTH = WORD_LENGTH,
  parameter int TAG_W = TAG_LENGTH,
  localparam int EXP_W = exp_w(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  input  logic signed [WIDTH-1:0] d,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        n1,
  output logic [WIDTH-1:0]        d1,
  output logic [WIDTH-1:0]        n2,
  output logic [WIDTH-1:0]        d2,
  output logic signed [EXP_W-1:0] k1,
  output logic signed [EXP_W-1:0] k2,
  output logic                    sx1,
  output logic                    sx2,
  output logic [3:0]              nz_flags,
  output logic                    ovf,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int IDX_W = EXP_W - 1;

  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  // Stage 1: sums in WIDTH+1 bits cannot overflow.
  logic [WIDTH:0]   s1_cpb, s1_dma, s1_cmb, s1_dpa;
  logic [TAG_W-1:0] s1_tag;
  logic [WIDTH:0]   ea, eb, ec, ed;

  assign ea = {a[WIDTH-1], a};
  assign eb = {b[WIDTH-1], b};
  assign ec = {c[WIDTH-1], c};
  assign ed = {d[WIDTH-1], d};

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      s1_cpb <= '0;
      s1_dma <= '0;
      s1_cmb <= '0;
      s1_dpa <= '0;
      s1_tag <= '0;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_cpb <= ec + eb;
        s1_dma <= ed - ea;
        s1_cmb <= ec - eb;
        s1_dpa <= ed + ea;
        s1_tag <= in_tag;
      end
    end
  end

  // Stage 2: magnitude, doubling for D, then reduction to WIDTH bits.
  function automatic logic [WIDTH:0] mag(input logic [WIDTH:0] v);
    return v[WIDTH] ? (~v + 1'b1) : v;
  endfunction

  // Returns {overflow, reduced value}.
  function automatic logic [WIDTH:0] reduce(input logic [WIDTH+1:0] v);
    logic o;
    o = |v[WIDTH+1:WIDTH];
`ifdef SVD_ROT_SAT_EN
    return {o, o ? {WIDTH{1'b1}} : v[WIDTH-1:0]};
`else
    return {o, v[WIDTH-1:0]};
`endif
  endfunction

  logic [WIDTH:0] r_n1, r_d1, r_n2, r_d2;

  assign r_n1 = reduce({1'b0, mag(s1_cpb)});
  assign r_d1 = reduce({mag(s1_dma), 1'b0});
  assign r_n2 = reduce({1'b0, mag(s1_cmb)});
  assign r_d2 = reduce({mag(s1_dpa), 1'b0});

  logic [WIDTH-1:0] s2_n1, s2_d1, s2_n2, s2_d2;
  logic             s2_sn1, s2_sd1, s2_sn2, s2_sd2;
  logic [3:0]       s2_ovf;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2     <= 1'b0;
      s2_n1  <= '0;
      s2_d1  <= '0;
      s2_n2  <= '0;
      s2_d2  <= '0;
      s2_sn1 <= 1'b0;
      s2_sd1 <= 1'b0;
      s2_sn2 <= 1'b0;
      s2_sd2 <= 1'b0;
      s2_ovf <= '0;
      s2_tag <= '0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s2_n1  <= r_n1[WIDTH-1:0];
        s2_d1  <= r_d1[WIDTH-1:0];
        s2_n2  <= r_n2[WIDTH-1:0];
        s2_d2  <= r_d2[WIDTH-1:0];
        s2_sn1 <= s1_cpb[WIDTH];
        s2_sd1 <= s1_dma[WIDTH];
        s2_sn2 <= s1_cmb[WIDTH];
        s2_sd2 <= s1_dpa[WIDTH];
        s2_ovf <= {r_n1[WIDTH], r_d1[WIDTH], r_n2[WIDTH], r_d2[WIDTH]};
        s2_tag <= s2_tag_next(s1_tag);
      end
    end
  end

  function automatic logic [TAG_W-1:0] s2_tag_next(input logic [TAG_W-1:0] t);
    return t;
  endfunction

  // Stage 3: exponent differences on the reduced values.
  logic [IDX_W-1:0] m_n1, m_d1, m_n2, m_d2;
  logic             z_n1, z_d1, z_n2, z_d2;

  svd_msb_encode #(.WIDTH(WIDTH)) u_msb_n1 (.x(s2_n1), .idx(m_n1), .zero(z_n1));
  svd_msb_encode #(.WIDTH(WIDTH)) u_msb_d1 (.x(s2_d1), .idx(m_d1), .zero(z_d1));
  svd_msb_encode #(.WIDTH(WIDTH)) u_msb_n2 (.x(s2_n2), .idx(m_n2), .zero(z_n2));
  svd_msb_encode #(.WIDTH(WIDTH)) u_msb_d2 (.x(s2_d2), .idx(m_d2), .zero(z_d2));

  always_ff @(posedge clk) begin
    if (rst) begin
      v3       <= 1'b0;
      n1       <= '0;
      d1       <= '0;
      n2       <= '0;
      d2       <= '0;
      k1       <= '0;
      k2       <= '0;
      sx1      <= 1'b0;
      sx2      <= 1'b0;
      nz_flags <= '0;
      ovf      <= 1'b0;
      out_tag  <= '0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        n1       <= s2_n1;
        d1       <= s2_d1;
        n2       <= s2_n2;
        d2       <= s2_d2;
        k1       <= {1'b0, m_d1} - {1'b0, m_n1};
        k2       <= {1'b0, m_d2} - {1'b0, m_n2};
        sx1      <= s2_sd1 ^ s2_sn1;
        sx2      <= s2_sd2 ^ s2_sn2;
        nz_flags <= {z_n1, z_d1, z_n2, z_d2};
        ovf      <= |s2_ovf;
        out_tag  <= s2_tag;
      end
    end
  end

endmodule

`default_nettype wire
